logic_gate_bist_ctrl: RTL
=========================

Name: logic_gate_bist_ctrl

Overview:
Self-test sequencer for the shared two-input logic-gate unit (and/or/not/nand/nor/xor/xnor).
- On a start pulse it drives the four input vectors 00, 01, 10, 11 onto the unit's a/b inputs.
- It holds each vector for a programmable number of cycles, samples the seven gate results, and compares them against the golden truth table.
- It reports pass/fail, a per-gate failure mask, and a failing-vector count.
- It sits between the top-level test/control logic and the combinational gate unit.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is driven before sampling; legal range 1..255. The hold counter is sized $clog2(HOLD_CYCLES+1) bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  run request; sampled only in IDLE.
- gate_res  input  7  results from the gate unit: bit0 and, bit1 or, bit2 not (= ~a), bit3 nand, bit4 nor, bit5 xor, bit6 xnor.
- a_out  output  1  drives gate unit input a.
- b_out  output  1  drives gate unit input b.
- vec_idx  output  2  index of the vector currently driven; index = {a_out, b_out}.
- busy  output  1  high while in APPLY.
- done  output  1  single-cycle pulse when a run completes.
- pass  output  1  high when the last completed run had no mismatches; held until the next accepted start or reset.
- fail_mask  output  7  OR over all vectors of the mismatching gate_res bits.
- fail_count  output  3  number of vectors (0..4) with at least one mismatching bit.

Behaviour:
- Reset: when rst is high at a clock edge, the following all take effect after that edge, and rst has priority over every other event including start:
  - state = IDLE
  - a_out = b_out = 0, vec_idx = 0
  - busy = done = pass = 0
  - fail_mask = 0, fail_count = 0
  - hold counter = 0
- States: IDLE, APPLY, DONE.
- IDLE: outputs hold their last values. If start = 1 at an edge:
  - go to APPLY; vec_idx = 0, a_out = 0, b_out = 0
  - hold counter = HOLD_CYCLES-1
  - fail_mask, fail_count and pass are cleared; busy = 1
- APPLY, hold counter != 0: decrement the counter; a_out and b_out are stable.
- APPLY, hold counter == 0 (last hold cycle): sample gate_res combinationally this cycle.
  - Expected value: {a^~b, a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, using the registered a_out/b_out.
  - mism = gate_res ^ expected.
  - At the edge: fail_mask |= mism; fail_count += (mism != 0).
  - If vec_idx == 3: go to DONE and set busy = 0.
  - Otherwise: vec_idx += 1, update a_out/b_out to the new index, and reload the counter with HOLD_CYCLES-1.
- Each vector is therefore driven for exactly HOLD_CYCLES cycles, with no gap cycles between vectors.
- DONE: lasts one cycle.
  - done = 1 and pass = (fail_mask == 0) are both visible in this cycle.
  - Next state is IDLE; done returns to 0.
  - a_out/b_out stay at 11 and vec_idx stays at 3 until the next start.
- Latency: start is accepted at edge E0. APPLY occupies cycles 1..4*HOLD_CYCLES after E0. done is high in cycle 4*HOLD_CYCLES+1.
- start during APPLY or DONE is ignored, with no queuing. A start held high continuously retriggers only from IDLE, i.e. one cycle after the done pulse.
- fail_count saturates naturally at 4 and never wraps, since only 4 vectors exist.
- rst mid-run aborts the run immediately: no done pulse and no partial results retained.
- gate_res is sampled only on the last hold cycle; glitches earlier in the hold window are ignored.

Test Plan:
1. HOLD_CYCLES=10, correct golden gate model, 1-cycle start pulse -> a/b = 00, 01, 10, 11, each for 10 cycles; busy high for 40 cycles; done pulse in cycle 41; pass=1, fail_mask=7'b0000000, fail_count=0.
2. xor output stuck-at-0 -> mismatches on vectors 01 and 10; done with pass=0, fail_mask=7'b0100000, fail_count=2.
3. not output wired as a instead of ~a -> mismatch on every vector; fail_mask=7'b0000100, fail_count=4, pass=0.
4. start re-pulsed at cycles 5 and 25 of a run, then pulsed again after done, with a failing model on run 1 and a correct model on run 2 -> mid-run pulses ignored (vector timing unchanged); the second run clears the prior results and ends with pass=1, fail_mask=0.
5. rst asserted for one cycle at cycle 15 of a run -> next cycle: busy=0, a_out=b_out=0, vec_idx=0, fail_mask=0, pass=0, and no done pulse; a following start runs the full 4-vector sequence.
6. HOLD_CYCLES=1 -> each vector is driven for 1 cycle (00, 01, 10, 11 in cycles 1..4 after the start edge); done in cycle 5; results match scenario 1.

Source files
------------

// File: rtl/logic_gate_bist_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : logic_gate_bist_ctrl_if
// Description : Bundle between the gate-unit BIST sequencer and its
//               surroundings (run control, gate unit stimulus/response, status).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
interface logic_gate_bist_ctrl_if;
  logic       start;
  logic [6:0] gate_res;
  logic       a_out;
  logic       b_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [2:0] fail_count;

  // master: the sequencer itself
  modport master (
    input  start, gate_res,
    output a_out, b_out, vec_idx, busy, done, pass, fail_mask, fail_count
  );

  // slave: control logic and gate unit around the sequencer
  modport slave (
    output start, gate_res,
    input  a_out, b_out, vec_idx, busy, done, pass, fail_mask, fail_count
  );
endinterface
`default_nettype wire

// File: rtl/logic_gate_bist_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : logic_gate_bist_ctrl
// Description : Walks vectors 00,01,10,11 through the shared logic-gate unit
//               and checks all seven results against the golden truth table.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module logic_gate_bist_ctrl #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  logic_gate_bist_ctrl_if.master        bus
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  C_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       vec_q,   vec_d;
  logic [6:0]       mask_q,  mask_d;
  logic [2:0]       count_q, count_d;
  logic             pass_q,  pass_d;
  logic [6:0]       exp_res;
  logic [6:0]       mism;
  logic             a_cur, b_cur;

  assign a_cur = vec_q[1];
  assign b_cur = vec_q[0];

  // Golden truth table for the currently driven (registered) vector
  assign exp_res = {~(a_cur ^ b_cur), a_cur ^ b_cur, ~(a_cur | b_cur),
                    ~(a_cur & b_cur), ~a_cur, a_cur | b_cur, a_cur & b_cur};
  assign mism    = bus.gate_res ^ exp_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    count_d = count_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_APPLY;
          vec_d   = 2'd0;
          cnt_d   = C_RELOAD;
          mask_d  = 7'd0;
          count_d = 3'd0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last hold cycle: gate_res is only trusted here
          mask_d  = mask_q | mism;
          count_d = count_q + {2'b00, |mism};
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
            pass_d  = ((mask_q | mism) == 7'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            cnt_d = C_RELOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      mask_q  <= 7'd0;
      count_q <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.a_out      = a_cur;
  assign bus.b_out      = b_cur;
  assign bus.vec_idx    = vec_q;
  assign bus.busy       = (state_q == S_APPLY);
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_count = count_q;

endmodule
`default_nettype wire
